// File: rtl/mux8_rr_arbiter_if.sv
// Purpose: handshake/bus bundle between the 8 requesters, the arbiter and the downstream consumer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls the granted requester; out_valid never drops while stalled.
interface mux8_rr_arbiter_if;
  logic [7:0] req;        // per-requester request for the shared mux
  logic [7:0] lock;       // per-requester multi-beat hold request
  logic       out_ready;  // downstream accepts the muxed result
  logic [2:0] sel;        // registered mux select
  logic [7:0] grant;      // registered one-hot grant, zero when idle
  logic       out_valid;  // muxed result valid
  logic [7:0] ack;        // one-hot transfer pulse
  logic       busy;       // arbiter holds a grant

  // Requester/consumer side: drives requests and ready, observes grant and handshake
  modport master (
    output req, lock, out_ready,
    input  sel, grant, out_valid, ack, busy
  );

  // Arbiter side
  modport slave (
    input  req, lock, out_ready,
    output sel, grant, out_valid, ack, busy
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Purpose: round-robin arbiter driving the select of a shared 8:1 result mux, with bounded locked bursts.
// Latency: one cycle from request to grant when idle; zero-bubble re-arbitration on a releasing transfer.
// Backpressure: without out_ready the grant, select, pointer and beat count all hold and out_valid stays up.
module mux8_rr_arbiter #(
  parameter int unsigned LOCK_MAX = 4   // max consecutive locked transfers per grant, 1..15
) (
  input logic              clk,
  input logic              rst_n,
  mux8_rr_arbiter_if.slave arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;     // highest-priority index for the next arbitration
  logic [2:0] sel_q,   sel_d;
  logic [7:0] grant_q, grant_d;
  logic [3:0] beat_q,  beat_d;    // transfers already made under the current locked grant

  logic       out_valid;
  logic       xfer;
  logic [4:0] beat_inc;
  logic [2:0] ptr_rel;            // pointer after releasing the current owner
  logic [2:0] win_idle;           // winner searched from the stored pointer
  logic [2:0] win_rel;            // winner searched from the post-release pointer
  logic       lock_limit;         // locked burst reached its maximum length

  // First requesting index in circular order starting at p.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Handshake decode: valid only while the owner still requests; ack mirrors the transfer.
  always_comb begin
    out_valid  = (state_q == GRANT) && arb.req[sel_q];
    xfer       = out_valid && arb.out_ready;
    beat_inc   = {1'b0, beat_q} + 5'd1;
    lock_limit = !(beat_inc < 5'(LOCK_MAX));
    ptr_rel    = sel_q + 3'd1;
    win_idle   = rr_pick(arb.req, ptr_q);
    win_rel    = rr_pick(arb.req, ptr_rel);
  end

  // Next-state: grant issue, hold under backpressure, locked bursts, release and back-to-back re-arbitration.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    beat_d  = beat_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        beat_d  = '0;
        if (|arb.req) begin
          sel_d   = win_idle;
          grant_d = 8'd1 << win_idle;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (!arb.req[sel_q]) begin
          // Owner withdrew before transferring: give up without moving the pointer.
          state_d = IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else if (xfer) begin
          if (arb.lock[sel_q] && !lock_limit) begin
            beat_d = beat_q + 4'd1;
          end else begin
            // Releasing transfer: owner drops to lowest priority, next winner picked now.
            ptr_d  = ptr_rel;
            beat_d = '0;
            if (|arb.req) begin
              sel_d   = win_rel;
              grant_d = 8'd1 << win_rel;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State registers; reset abandons any grant in flight and restarts priority at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  // Output drive
  always_comb begin
    arb.sel       = sel_q;
    arb.grant     = grant_q;
    arb.busy      = (state_q == GRANT);
    arb.out_valid = out_valid;
    arb.ack       = xfer ? (8'd1 << sel_q) : 8'd0;
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Purpose: self-checking bench for mux8_rr_arbiter: directed scenarios with literal expectations plus random traffic.
// Latency: a behavioural owner/pointer model predicts every output each cycle.
// Backpressure: random out_ready exercises stalls and locked bursts.
module tb_mux8_rr_arbiter;
  localparam int LOCK_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux8_rr_arbiter_if arb_if ();

  mux8_rr_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: who owns the mux, whose turn is next ----------------
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_next  = 0;   // first index to consider next time
  int m_done  = 0;   // transfers made by the owner in this grant

  bit n_busy;
  int n_owner, n_next, n_done;

  function automatic int first_req(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++)
      if (r[(start + k) % 8]) return (start + k) % 8;
    return -1;
  endfunction

  always_comb begin
    n_busy  = m_busy;
    n_owner = m_owner;
    n_next  = m_next;
    n_done  = m_done;
    if (!m_busy) begin
      if (arb_if.req != 8'd0) begin
        n_owner = first_req(arb_if.req, m_next);
        n_busy  = 1'b1;
        n_done  = 0;
      end
    end else if (!arb_if.req[m_owner]) begin
      n_busy = 1'b0;
      n_done = 0;
    end else if (arb_if.out_ready) begin
      if (arb_if.lock[m_owner] && (m_done + 1) < LOCK_MAX) begin
        n_done = m_done + 1;
      end else begin
        n_next = (m_owner + 1) % 8;
        n_done = 0;
        if (arb_if.req != 8'd0) n_owner = first_req(arb_if.req, n_next);
        else                    n_busy  = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_next  <= 0;
      m_done  <= 0;
    end else begin
      m_busy  <= n_busy;
      m_owner <= n_owner;
      m_next  <= n_next;
      m_done  <= n_done;
    end
  end

  // ---------------- every-cycle compare against the model ----------------
  always @(negedge clk) begin
    logic       e_valid;
    logic [7:0] e_grant, e_ack;
    e_grant = m_busy ? 8'(1 << m_owner) : 8'd0;
    e_valid = m_busy && arb_if.req[m_owner];
    e_ack   = (e_valid && arb_if.out_ready) ? 8'(1 << m_owner) : 8'd0;
    chk("model_busy",   32'(arb_if.busy),      32'(m_busy));
    chk("model_sel",    32'(arb_if.sel),       32'(m_owner));
    chk("model_grant",  32'(arb_if.grant),     32'(e_grant));
    chk("model_valid",  32'(arb_if.out_valid), 32'(e_valid));
    chk("model_ack",    32'(arb_if.ack),       32'(e_ack));
    chk("grant_onehot0", 32'($onehot0(arb_if.grant)), 32'd1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    arb_if.req       = 8'd0;
    arb_if.lock      = 8'd0;
    arb_if.out_ready = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(arb_if.grant),     32'd0);
    chk("rst_sel",   32'(arb_if.sel),       32'd0);
    chk("rst_busy",  32'(arb_if.busy),      32'd0);
    chk("rst_valid", 32'(arb_if.out_valid), 32'd0);
    chk("rst_ack",   32'(arb_if.ack),       32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    arb_if.req       = 8'd0;
    arb_if.lock      = 8'd0;
    arb_if.out_ready = 1'b0;
    #1;

    // Two requesters, back-to-back service with no idle gap
    do_reset();
    arb_if.req       = 8'b0010_0100;
    arb_if.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_idle_grant", 32'(arb_if.grant), 32'd0);
    tick();
    @(negedge clk);
    chk("b2b_first_grant", 32'(arb_if.grant), 32'h04);
    chk("b2b_first_sel",   32'(arb_if.sel),   32'd2);
    chk("b2b_first_ack",   32'(arb_if.ack),   32'h04);
    tick();
    @(negedge clk);
    chk("b2b_second_grant", 32'(arb_if.grant), 32'h20);
    chk("b2b_second_sel",   32'(arb_if.sel),   32'd5);
    chk("b2b_second_ack",   32'(arb_if.ack),   32'h20);
    tick();
    @(negedge clk);
    chk("b2b_wrap_sel", 32'(arb_if.sel), 32'd2);

    // All requesting: strict rotation, one ack per cycle
    do_reset();
    arb_if.req       = 8'hFF;
    arb_if.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rot_sel", 32'(arb_if.sel), 32'(i % 8));
      chk("rot_ack", 32'(arb_if.ack), 32'(1 << (i % 8)));
      tick();
    end

    // Backpressure on requester 3, other requests arriving meanwhile
    do_reset();
    arb_if.req = 8'h08;
    tick();
    arb_if.req = 8'h1A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(arb_if.out_valid), 32'd1);
      chk("stall_sel",   32'(arb_if.sel),       32'd3);
      chk("stall_ack",   32'(arb_if.ack),       32'd0);
      tick();
    end
    arb_if.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ack", 32'(arb_if.ack), 32'h08);
    tick();
    @(negedge clk);
    chk("stall_next_sel", 32'(arb_if.sel), 32'd4);

    // Locked burst capped at LOCK_MAX beats
    do_reset();
    arb_if.req       = 8'h03;
    arb_if.lock      = 8'h01;
    arb_if.out_ready = 1'b1;
    tick();
    for (int i = 0; i < LOCK_MAX; i++) begin
      @(negedge clk);
      chk("lock_ack", 32'(arb_if.ack), 32'h01);
      tick();
    end
    @(negedge clk);
    chk("lock_forced_sel", 32'(arb_if.sel), 32'd1);
    chk("lock_forced_ack", 32'(arb_if.ack), 32'h02);
    arb_if.lock = 8'd0;

    // Owner withdraws before transferring
    do_reset();
    arb_if.req = 8'h40;
    tick();
    @(negedge clk);
    chk("drop_sel", 32'(arb_if.sel), 32'd6);
    tick();
    arb_if.req = 8'h00;
    @(negedge clk);
    chk("drop_valid", 32'(arb_if.out_valid), 32'd0);
    chk("drop_ack",   32'(arb_if.ack),       32'd0);
    tick();
    @(negedge clk);
    chk("drop_grant", 32'(arb_if.grant), 32'd0);
    chk("drop_busy",  32'(arb_if.busy),  32'd0);
    arb_if.req = 8'h40;
    tick();
    @(negedge clk);
    chk("drop_regrant", 32'(arb_if.grant), 32'h40);

    // Reset in the middle of a grant
    do_reset();
    arb_if.req       = 8'h80;
    arb_if.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_ack7", 32'(arb_if.ack), 32'h80);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(arb_if.grant),     32'd0);
    chk("mid_rst_valid", 32'(arb_if.out_valid), 32'd0);
    chk("mid_rst_ack",   32'(arb_if.ack),       32'd0);
    chk("mid_rst_busy",  32'(arb_if.busy),      32'd0);
    tick();
    rst_n      = 1'b1;
    arb_if.req = 8'h81;
    tick();
    @(negedge clk);
    chk("post_rst_sel", 32'(arb_if.sel), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0)
        arb_if.req = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      arb_if.lock      = 8'($urandom_range(0, 255));
      arb_if.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else                             rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
